// File: rtl/dmem_bridge.sv
// dmem_bridge: memory-stage to data-RAM request/ack bridge with load formatting; optional bus timeout via `DMEM_TIMEOUT_EN
module dmem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [3:0]  dre,
    input  logic [31:0] din,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wen,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall_o,
    output logic        dvalid_o,
    output logic [31:0] drdata_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_dre;
    logic        r_dvalid;
    logic [31:0] r_drdata;
    logic [31:0] w_fmt;
    logic        w_load;
    logic        w_ack;
    logic        w_timeout;
    logic        w_unused;

    assign w_unused = ^{daddr[1:0], TIMEOUT_CYCLES[0]};
    assign w_load   = (bus_wen == 4'b0000) && (r_dre != 4'b0000);
    assign w_ack    = (r_state == REQ) && bus_ack;
    assign dvalid_o = r_dvalid;
    assign drdata_o = r_drdata;

`ifdef DMEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    assign w_timeout = (r_state == REQ) && !bus_ack && (r_cnt == TO_LAST);
    assign err_o     = r_err;

    // Count REQ cycles from zero on entry; the last allowed cycle without ack times out
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == REQ) ? r_cnt + 1'b1 : '0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // State register
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state: accept only from IDLE, leave REQ on ack (or timeout), DONE lasts one cycle
    always_comb begin
        w_next = (r_state == IDLE) ? (dce ? REQ : IDLE) :
                 (r_state == REQ)  ? ((bus_ack || w_timeout) ? DONE : REQ) :
                                     IDLE;
    end

    // Outputs decoded from state; stall covers the accepting IDLE cycle and all of REQ
    always_comb begin
        bus_req = (r_state == REQ);
        stall_o = ((r_state == IDLE) && dce) || (r_state == REQ);
    end

    // Capture the access when leaving IDLE; held stable for the whole REQ phase
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            bus_addr  <= '0;
            bus_wen   <= '0;
            bus_wdata <= '0;
            r_dre     <= '0;
        end else if ((r_state == IDLE) && dce) begin
            bus_addr  <= {daddr[31:2], 2'b00};
            bus_wen   <= we;
            bus_wdata <= din;
            r_dre     <= dre;
        end
    end

    // Load formatting: full word is byte-reversed, a single lane is sign-extended, anything else reads as zero
    always_comb begin
        w_fmt = (r_dre == 4'b1111) ? {bus_rdata[7:0], bus_rdata[15:8], bus_rdata[23:16], bus_rdata[31:24]} :
                (r_dre == 4'b0001) ? {{24{bus_rdata[7]}},  bus_rdata[7:0]}   :
                (r_dre == 4'b0010) ? {{24{bus_rdata[15]}}, bus_rdata[15:8]}  :
                (r_dre == 4'b0100) ? {{24{bus_rdata[23]}}, bus_rdata[23:16]} :
                (r_dre == 4'b1000) ? {{24{bus_rdata[31]}}, bus_rdata[31:24]} :
                                     32'h0;
    end

    // Result register: loaded on REQ->DONE for non-stores, zeroed on timeout, untouched by stores
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_dvalid <= 1'b0;
            r_drdata <= '0;
        end else begin
            r_dvalid <= w_ack && w_load;
            if (w_timeout)
                r_drdata <= '0;
            else if (w_ack && (bus_wen == 4'b0000))
                r_drdata <= w_fmt;
        end
    end
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum cycles spent waiting for bus_ack (used only with DMEM_TIMEOUT_EN).
REQ-002 SHALL have port cpu_clk_50M, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port cpu_rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port dce, input, 1, memory-stage access enable.
REQ-005 SHALL have port daddr, input, 32, memory-stage byte address.
REQ-006 SHALL have port we, input, 4, byte write enables (lane 3 = addr[1:0]==00).
REQ-007 SHALL have port dre, input, 4, byte read enables, same lane mapping as we.
REQ-008 SHALL have port din, input, 32, store data, already lane-formatted.
REQ-009 SHALL have port bus_req, output, 1, registered request to data RAM.
REQ-010 SHALL have port bus_addr, output, 32, word address {daddr[31:2],2'b00}.
REQ-011 SHALL have port bus_wen, output, 4, latched we.
REQ-012 SHALL have port bus_wdata, output, 32, latched din.
REQ-013 SHALL have port bus_ack, input, 1, one-cycle completion pulse from RAM.
REQ-014 SHALL have port bus_rdata, input, 32, RAM read data, valid with bus_ack.
REQ-015 SHALL have port stall_o, output, 1, holds the pipeline while an access is outstanding.
REQ-016 SHALL have port dvalid_o, output, 1, load result valid.
REQ-017 SHALL have port drdata_o, output, 32, formatted load result.
REQ-018 SHALL have port err_o, output, 1, sticky bus-timeout flag.

Function
REQ-019 SHALL implement FSM IDLE, REQ, DONE; IDLE->REQ when dce=1; REQ->DONE on bus_ack=1; DONE->IDLE unconditionally.
REQ-020 SHALL latch bus_addr, bus_wen, bus_wdata, dre on the IDLE->REQ edge; they SHALL remain stable throughout REQ.
REQ-021 SHALL drive bus_req=1 exactly while in REQ; bus_ack outside REQ SHALL be ignored.
REQ-022 SHALL drive stall_o = (IDLE & dce) | REQ, combinationally; stall_o=0 in DONE.
REQ-023 SHALL ignore dce in DONE (same instruction still presented); a new access is accepted only from IDLE.
REQ-024 SHALL register the formatted read data on the REQ->DONE edge; dvalid_o=1 only in DONE, and only if latched dre!=0.
REQ-025 SHALL format loads as follows: dre=1111 gives the byte-reversed word {rd[7:0],rd[15:8],rd[23:16],rd[31:24]}; a single dre bit k selects byte rd[8k+7:8k], sign-extended to 32 bits; any other dre value gives 0.
REQ-026 SHALL treat a store (latched we!=0) as complete on bus_ack, with dvalid_o=0 and drdata_o unchanged.
REQ-027 SHALL handle minimum latency as follows: with ack in the first REQ cycle, stall lasts 2 cycles and the result appears in the 3rd cycle.

Reset
REQ-028 SHALL, on cpu_rst=1 (asynchronous, including mid-transaction), force IDLE with bus_req=0, bus_addr=0, bus_wen=0, bus_wdata=0, dvalid_o=0, drdata_o=0, err_o=0; stall_o then follows dce.

Configuration
REQ-029 SHALL, with DMEM_TIMEOUT_EN defined, count REQ cycles; at count==TIMEOUT_CYCLES without ack, go to DONE with drdata_o=0, dvalid_o=0, and set err_o=1 until reset; the counter SHALL clear on entering REQ.
REQ-030 SHALL, without DMEM_TIMEOUT_EN, omit the counter, wait indefinitely in REQ, and tie err_o to 0.

Verification
REQ-031 SHALL test lw as follows: dce=1, dre=1111, daddr=0x104, ack after 3 cycles with rdata=0x11223344 -> bus_addr=0x104, stall 4 cycles, drdata_o=0x44332211, dvalid_o=1 for one cycle.
REQ-032 SHALL test lb as follows: dre=0100, daddr=0x201, rdata=0x00F50000 -> drdata_o=0xFFFFFFF5; same test with rdata byte 0x75 -> 0x00000075.
REQ-033 SHALL test sb as follows: we=0001, daddr=0x2B, din=0xABABABAB -> bus_addr=0x28, bus_wen=0001, bus_wdata=0xABABABAB, dvalid_o=0.
REQ-034 SHALL test back-to-back access as follows: a second access presented in the DONE cycle is not started; the next cycle's dce=1 starts REQ for the new access.
REQ-035 SHALL test reset during REQ as follows: bus_req falls asynchronously to 0, and no dvalid_o pulse follows.
REQ-036 SHALL test timeout as follows: with DMEM_TIMEOUT_EN and no ack, after 255 REQ cycles err_o=1, stall_o releases, and drdata_o=0.
